// File: rtl/page_store_mux_if.sv
// Pixel bus between the scan generator, the shared page ROMs and the page mux.
// The slave side is the mux; the master side is the scan generator plus ROM bank.
interface page_store_mux_if #(
    parameter int NUM_PAGES = 5,
    parameter int ADDR_W    = 17,
    parameter int PIX_W     = 12
);
    logic [ADDR_W-1:0]          addr_in;
    logic                       addr_vld;
    logic [ADDR_W-1:0]          rom_addr;
    logic [NUM_PAGES*PIX_W-1:0] rom_data;
    logic [PIX_W-1:0]           rgb;
    logic                       rgb_vld;

    modport master (
        output addr_in, addr_vld, rom_data,
        input  rom_addr, rgb, rgb_vld
    );

    modport slave (
        input  addr_in, addr_vld, rom_data,
        output rom_addr, rgb, rgb_vld
    );
endinterface

// File: rtl/page_store_mux.sv
// Page selection for the reader display: holds the current page, commits page turns
// only at frame_start, and muxes the tagged ROM read back to the VGA driver.
module page_store_mux #(
    parameter int               NUM_PAGES = 5,
    parameter int               PAGE_W    = 3,
    parameter int               ADDR_W    = 17,
    parameter int               PIX_W     = 12,
    parameter int               ROM_LAT   = 1,
    parameter int               WRAP      = 1,
    parameter logic [PIX_W-1:0] BLANK_RGB = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              page_next,
    input  logic              page_prev,
    input  logic              page_load,
    input  logic [PAGE_W-1:0] page_sel,
    page_store_mux_if.slave   bus,
    output logic [PAGE_W-1:0] page_cur,
    output logic              turn_pending
);

    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);

    logic [PAGE_W-1:0] page_req;
    logic [PAGE_W-1:0] req_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [ROM_LAT:0]  vld_p;
    logic [PAGE_W-1:0] tag_p [0:ROM_LAT];
    logic [PIX_W-1:0]  sel_pix;
    logic [PIX_W-1:0]  rgb_q;
    logic              rgb_vld_q;

    // next/prev step from page_req so several pulses inside one frame accumulate
    always_comb begin
        req_nxt = page_req;
        if (page_load) begin
            req_nxt = (page_sel > LAST_PAGE) ? LAST_PAGE : page_sel;
        end else if (page_next) begin
            if (page_req == LAST_PAGE)
                req_nxt = (WRAP != 0) ? '0 : page_req;
            else
                req_nxt = page_req + PAGE_W'(1);
        end else if (page_prev) begin
            if (page_req == '0)
                req_nxt = (WRAP != 0) ? LAST_PAGE : page_req;
            else
                req_nxt = page_req - PAGE_W'(1);
        end
    end

    // frame_start commits the request held before this edge, so a same-cycle pulse waits a frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            page_req     <= '0;
            page_cur     <= '0;
            turn_pending <= 1'b0;
        end else begin
            page_req     <= req_nxt;
            turn_pending <= (page_req != page_cur);
            if (frame_start)
                page_cur <= page_req;
        end
    end

    always_comb begin
        sel_pix = BLANK_RGB;
        for (int k = 0; k < NUM_PAGES; k++) begin
            if (tag_p[ROM_LAT] == PAGE_W'(k))
                sel_pix = bus.rom_data[k*PIX_W +: PIX_W];
        end
    end

    // each pixel carries its page tag through the ROM latency, so commits never split a pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            vld_p     <= '0;
            rgb_q     <= BLANK_RGB;
            rgb_vld_q <= 1'b0;
            for (int i = 0; i <= ROM_LAT; i++)
                tag_p[i] <= '0;
        end else begin
            addr_q   <= bus.addr_in;
            vld_p[0] <= bus.addr_vld;
            tag_p[0] <= page_cur;
            for (int i = 1; i <= ROM_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                tag_p[i] <= tag_p[i-1];
            end
            rgb_q     <= vld_p[ROM_LAT] ? sel_pix : BLANK_RGB;
            rgb_vld_q <= vld_p[ROM_LAT];
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.rgb      = rgb_q;
    assign bus.rgb_vld  = rgb_vld_q;

endmodule

// File: tb/tb_page_store_mux.sv
// Directed bench for page_store_mux: a wrapping and a saturating instance share the
// control pulses; the wrapping one also streams pixels through a 1-cycle ROM model.
module tb_page_store_mux;

    localparam int NUM_PAGES = 5;
    localparam int PAGE_W    = 3;
    localparam int ADDR_W    = 17;
    localparam int PIX_W     = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic              page_next;
    logic              page_prev;
    logic              page_load;
    logic [PAGE_W-1:0] page_sel;
    logic [PAGE_W-1:0] page_cur_w, page_cur_n;
    logic              tp_w, tp_n;

    int total  = 0;
    int passed = 0;

    page_store_mux_if #(.NUM_PAGES(NUM_PAGES), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus_w ();
    page_store_mux_if #(.NUM_PAGES(NUM_PAGES), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus_n ();

    page_store_mux #(
        .NUM_PAGES(NUM_PAGES), .PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
        .ROM_LAT(1), .WRAP(1), .BLANK_RGB(12'h000)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .page_next(page_next), .page_prev(page_prev), .page_load(page_load),
        .page_sel(page_sel), .bus(bus_w.slave),
        .page_cur(page_cur_w), .turn_pending(tp_w)
    );

    page_store_mux #(
        .NUM_PAGES(NUM_PAGES), .PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
        .ROM_LAT(1), .WRAP(0), .BLANK_RGB(12'h000)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .page_next(page_next), .page_prev(page_prev), .page_load(page_load),
        .page_sel(page_sel), .bus(bus_n.slave),
        .page_cur(page_cur_n), .turn_pending(tp_n)
    );

    always #5 clk = ~clk;

    // page ROM k returns {k, addr[7:0]} one cycle after the address
    always @(posedge clk) begin
        for (int k = 0; k < NUM_PAGES; k++)
            bus_w.rom_data[k*PIX_W +: PIX_W] <= {4'(k), bus_w.rom_addr[7:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [PAGE_W-1:0] sel);
        page_load = 1'b1;
        page_sel  = sel;
        tick();
        page_load = 1'b0;
    endtask

    task automatic pulse_next();
        page_next = 1'b1;
        tick();
        page_next = 1'b0;
    endtask

    task automatic pulse_prev();
        page_prev = 1'b1;
        tick();
        page_prev = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [PIX_W-1:0] exp_rgb;
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (page_cur_w !== 3'd0) $display("FAIL reset_page_cur got=%0d exp=0", page_cur_w); else passed++;
        total++; if (tp_w !== 1'b0) $display("FAIL reset_turn_pending got=%b exp=0", tp_w); else passed++;
        total++; if (bus_w.rgb_vld !== 1'b0) $display("FAIL reset_rgb_vld got=%b exp=0", bus_w.rgb_vld); else passed++;
        total++; if (bus_w.rgb !== 12'h000) $display("FAIL reset_rgb got=%h exp=000", bus_w.rgb); else passed++;
        total++; if (bus_w.rom_addr !== 17'd0) $display("FAIL reset_rom_addr got=%h exp=0", bus_w.rom_addr); else passed++;
        rst_n = 1'b1;
        for (int j = 0; j < 14; j++) begin
            bus_w.addr_in  = ADDR_W'(j);
            bus_w.addr_vld = (j < 10);
            tick();
            if (j < 2 || j >= 12) begin
                total++; if (bus_w.rgb_vld !== 1'b0) $display("FAIL stream0_vld_low j=%0d got=%b exp=0", j, bus_w.rgb_vld); else passed++;
            end else begin
                exp_rgb = {4'h0, 8'(j - 2)};
                total++; if (bus_w.rgb_vld !== 1'b1) $display("FAIL stream0_vld j=%0d got=%b exp=1", j, bus_w.rgb_vld); else passed++;
                total++; if (bus_w.rgb !== exp_rgb) $display("FAIL stream0_rgb j=%0d got=%h exp=%h", j, bus_w.rgb, exp_rgb); else passed++;
            end
        end
    endtask

    task automatic test_turn_mid_frame();
        logic [PIX_W-1:0] exp_rgb;
        int a;
        for (int j = 0; j < 12; j++) begin
            bus_w.addr_in  = ADDR_W'(8'h40 + j);
            bus_w.addr_vld = 1'b1;
            page_next      = (j == 3);
            frame_start    = (j == 6);
            tick();
            if (j >= 2) begin
                a = j - 2;
                exp_rgb = {(a <= 6) ? 4'h0 : 4'h1, 8'(8'h40 + a)};
                total++; if (bus_w.rgb_vld !== 1'b1) $display("FAIL turn_vld j=%0d got=%b exp=1", j, bus_w.rgb_vld); else passed++;
                total++; if (bus_w.rgb !== exp_rgb) $display("FAIL turn_rgb j=%0d got=%h exp=%h", j, bus_w.rgb, exp_rgb); else passed++;
            end
            if (j == 5) begin
                total++; if (tp_w !== 1'b1) $display("FAIL turn_pending_set got=%b exp=1", tp_w); else passed++;
                total++; if (page_cur_w !== 3'd0) $display("FAIL turn_page_held got=%0d exp=0", page_cur_w); else passed++;
            end
            if (j == 6) begin
                total++; if (page_cur_w !== 3'd1) $display("FAIL turn_page_commit got=%0d exp=1", page_cur_w); else passed++;
            end
            if (j == 8) begin
                total++; if (tp_w !== 1'b0) $display("FAIL turn_pending_clear got=%b exp=0", tp_w); else passed++;
            end
        end
        page_next      = 1'b0;
        frame_start    = 1'b0;
        bus_w.addr_vld = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_wrap_next();
        pulse_load(3'd4);
        pulse_frame();
        total++; if (page_cur_w !== 3'd4) $display("FAIL wrap_setup_w got=%0d exp=4", page_cur_w); else passed++;
        total++; if (page_cur_n !== 3'd4) $display("FAIL wrap_setup_n got=%0d exp=4", page_cur_n); else passed++;
        pulse_next();
        pulse_frame();
        total++; if (page_cur_w !== 3'd0) $display("FAIL wrap_next_w got=%0d exp=0", page_cur_w); else passed++;
        total++; if (page_cur_n !== 3'd4) $display("FAIL sat_next_n got=%0d exp=4", page_cur_n); else passed++;
        repeat (2) tick();
        total++; if (tp_n !== 1'b0) $display("FAIL sat_next_pending got=%b exp=0", tp_n); else passed++;
        total++; if (tp_w !== 1'b0) $display("FAIL wrap_next_pending got=%b exp=0", tp_w); else passed++;
    endtask

    task automatic test_load();
        pulse_load(3'd7);
        tick();
        total++; if (tp_w !== 1'b1) $display("FAIL load_clamp_pending_w got=%b exp=1", tp_w); else passed++;
        total++; if (tp_n !== 1'b0) $display("FAIL load_clamp_pending_n got=%b exp=0", tp_n); else passed++;
        pulse_frame();
        total++; if (page_cur_w !== 3'd4) $display("FAIL load_clamp got=%0d exp=4", page_cur_w); else passed++;
        page_next = 1'b1;
        pulse_load(3'd2);
        page_next = 1'b0;
        pulse_frame();
        total++; if (page_cur_w !== 3'd2) $display("FAIL load_priority got=%0d exp=2", page_cur_w); else passed++;
    endtask

    task automatic test_wrap_prev();
        pulse_load(3'd0);
        pulse_frame();
        pulse_prev();
        pulse_frame();
        total++; if (page_cur_w !== 3'd4) $display("FAIL wrap_prev_w got=%0d exp=4", page_cur_w); else passed++;
        total++; if (page_cur_n !== 3'd0) $display("FAIL sat_prev_n got=%0d exp=0", page_cur_n); else passed++;
    endtask

    task automatic test_accumulate();
        pulse_load(3'd0);
        pulse_frame();
        for (int i = 0; i < 3; i++) begin
            pulse_next();
            tick();
        end
        total++; if (page_cur_w !== 3'd0) $display("FAIL accum_held got=%0d exp=0", page_cur_w); else passed++;
        pulse_frame();
        total++; if (page_cur_w !== 3'd3) $display("FAIL accum_commit got=%0d exp=3", page_cur_w); else passed++;
        page_next   = 1'b1;
        frame_start = 1'b1;
        tick();
        page_next   = 1'b0;
        frame_start = 1'b0;
        total++; if (page_cur_w !== 3'd3) $display("FAIL same_cycle_deferred got=%0d exp=3", page_cur_w); else passed++;
        tick();
        total++; if (tp_w !== 1'b1) $display("FAIL same_cycle_pending got=%b exp=1", tp_w); else passed++;
        pulse_frame();
        total++; if (page_cur_w !== 3'd4) $display("FAIL same_cycle_next_frame got=%0d exp=4", page_cur_w); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [PIX_W-1:0] exp_rgb;
        for (int j = 0; j < 4; j++) begin
            bus_w.addr_in  = ADDR_W'(8'h60 + j);
            bus_w.addr_vld = 1'b1;
            tick();
        end
        rst_n         = 1'b0;
        bus_w.addr_in = ADDR_W'(8'h64);
        tick();
        total++; if (bus_w.rgb_vld !== 1'b0) $display("FAIL midrst_vld got=%b exp=0", bus_w.rgb_vld); else passed++;
        total++; if (bus_w.rgb !== 12'h000) $display("FAIL midrst_rgb got=%h exp=000", bus_w.rgb); else passed++;
        total++; if (page_cur_w !== 3'd0) $display("FAIL midrst_page got=%0d exp=0", page_cur_w); else passed++;
        total++; if (bus_w.rom_addr !== 17'd0) $display("FAIL midrst_rom_addr got=%h exp=0", bus_w.rom_addr); else passed++;
        rst_n = 1'b1;
        for (int m = 0; m < 6; m++) begin
            bus_w.addr_in  = ADDR_W'(8'h77);
            bus_w.addr_vld = (m == 2);
            tick();
            exp_rgb = (m == 4) ? 12'h077 : 12'h000;
            total++; if (bus_w.rgb_vld !== (m == 4)) $display("FAIL resume_vld m=%0d got=%b exp=%b", m, bus_w.rgb_vld, (m == 4)); else passed++;
            total++; if (bus_w.rgb !== exp_rgb) $display("FAIL resume_rgb m=%0d got=%h exp=%h", m, bus_w.rgb, exp_rgb); else passed++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        frame_start    = 1'b0;
        page_next      = 1'b0;
        page_prev      = 1'b0;
        page_load      = 1'b0;
        page_sel       = '0;
        bus_w.addr_in  = '0;
        bus_w.addr_vld = 1'b0;
        bus_n.addr_in  = '0;
        bus_n.addr_vld = 1'b0;
        bus_n.rom_data = '0;

        test_reset();
        test_turn_mid_frame();
        test_wrap_next();
        test_load();
        test_wrap_prev();
        test_accumulate();
        test_reset_mid_frame();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
